macc_dot_driver: RTL and testbench

MACC_DOT_DRIVER -- requirements
Module: macc_dot_driver

---
 rtl/macc_dot_driver_if.sv | 26 ++
 rtl/macc_dot_driver.sv | 87 ++++++++
 tb/tb_macc_dot_driver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/macc_dot_driver_if.sv
// macc_dot_driver_if: start/len command, operand-pair stream and result stream of the dot-product driver
interface macc_dot_driver_if #(
  parameter int SIZEIN  = 16,
  parameter int SIZEOUT = 40,
  parameter int LENW    = 16
);
  logic                      start;
  logic [LENW-1:0]           len;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [SIZEIN-1:0]  in_a;
  logic signed [SIZEIN-1:0]  in_b;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [SIZEOUT-1:0] res_data;
  logic                      busy;
  logic                      len_err;
  modport master (
    output start, len, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, busy, len_err
  );
  modport slave (
    input  start, len, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, busy, len_err
  );
endinterface

// File: rtl/macc_dot_driver.sv
// macc_dot_driver: feeds operand pairs to a 3-stage MAC and captures each vector's dot product
module macc_dot_driver #(
  parameter int SIZEIN  = 16,
  parameter int SIZEOUT = 40,
  parameter int LENW    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  macc_dot_driver_if.slave          bus,
  output logic signed [SIZEIN-1:0]  macc_a,
  output logic signed [SIZEIN-1:0]  macc_b,
  output logic                      macc_sload,
  output logic                      macc_ce,
  input  logic signed [SIZEOUT-1:0] macc_accum
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]                state_q, state_d;
  logic [LENW-1:0]           rem_q, rem_d;
  logic                      first_q, first_d;
  logic                      fld_q, fld_d;
  logic                      sload_q, sload_d;
  logic                      rv_q, rv_d;
  logic                      lerr_q, lerr_d;
  logic signed [SIZEIN-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]                tag_q, tag_d;
  logic signed [SIZEOUT-1:0] rd_q, rd_d;
  logic                      run, ce, rdy, acc, last, go, cap;
  assign macc_a        = a_q;
  assign macc_b        = b_q;
  assign macc_sload    = sload_q;
  assign macc_ce       = ce;
  assign bus.in_ready  = rdy;
  assign bus.res_valid = rv_q;
  assign bus.res_data  = rd_q;
  assign bus.len_err   = lerr_q;
  assign bus.busy      = run | (|tag_q);
  // next-state logic; a start coinciding with the last pair is taken so vectors can run back to back
  always_comb begin
    run     = state_q == RUN;
    ce      = ~(tag_q[3] & rv_q & ~bus.res_ready);
    rdy     = run & ce;
    acc     = bus.in_valid & rdy;
    last    = acc & (rem_q == LENW'(1));
    go      = bus.start & (bus.len != '0) & (~run | last);
    lerr_d  = bus.start & (bus.len == '0) & (~run | last);
    state_d = go ? RUN : (last ? IDLE : state_q);
    rem_d   = go ? bus.len : (acc ? rem_q - LENW'(1) : rem_q);
    first_d = go | (first_q & ~acc);
    fld_d   = ce ? (acc & first_q) : fld_q;
    sload_d = ce ? fld_q : sload_q;
    a_d     = ce ? (acc ? bus.in_a : '0) : a_q;
    b_d     = ce ? (acc ? bus.in_b : '0) : b_q;
    tag_d   = ce ? {tag_q[2:0], last} : tag_q;
    cap     = ce & tag_q[3];
    rv_d    = cap | (rv_q & ~bus.res_ready);
    rd_d    = cap ? macc_accum : rd_q;
  end
  // state registers; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      fld_q   <= 1'b0;
      sload_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      fld_q   <= fld_d;
      sload_q <= sload_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      lerr_q  <= lerr_d;
    end
  end
endmodule

// File: tb/tb_macc_dot_driver.sv
// tb_macc_dot_driver: scoreboard bench with a behavioural 3-stage MAC model
module tb_macc_dot_driver;
  localparam int SI = 16;
  localparam int SO = 40;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst;
  logic signed [SI-1:0] macc_a, macc_b;
  logic macc_sload, macc_ce;
  logic signed [SI-1:0] ar = '0, br = '0;
  logic signed [SO-1:0] mr = '0, accum = '0;
  logic sr = 1'b0;
  logic signed [SO-1:0] exp_q[$];
  int qa[$], qb[$], ql[$];
  int total = 0, bad = 0, waits = 0;
  macc_dot_driver_if #(.SIZEIN(SI), .SIZEOUT(SO), .LENW(LW)) bus ();
  macc_dot_driver #(.SIZEIN(SI), .SIZEOUT(SO), .LENW(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .macc_a(macc_a), .macc_b(macc_b), .macc_sload(macc_sload),
    .macc_ce(macc_ce), .macc_accum(accum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (macc_ce) begin
      ar    <= macc_a;
      br    <= macc_b;
      mr    <= SO'(ar) * SO'(br);
      sr    <= macc_sload;
      accum <= (sr ? '0 : accum) + mr;
    end
  end
  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%0d required=none", bus.res_data);
      end else chk("result", bus.res_data, exp_q.pop_front());
    end
  end
  task automatic wait_acc();
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    waits += n - 1;
  endtask
  task automatic drive(input int gap);
    int k;
    logic signed [63:0] s;
    k = 0;
    for (int v = 0; v < ql.size(); v++) begin
      s = 0;
      for (int p = 0; p < ql[v]; p++) s += qa[k+p] * qb[k+p];
      exp_q.push_back(SO'(s));
      if (v == 0 || gap != 0) begin
        bus.start = 1'b1;
        bus.len = LW'(ql[v]);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      for (int p = 0; p < ql[v]; p++) begin
        bus.in_valid = 1'b1;
        bus.in_a = SI'(qa[k]);
        bus.in_b = SI'(qb[k]);
        k++;
        if (p == ql[v] - 1 && gap == 0 && v + 1 < ql.size()) begin
          bus.start = 1'b1;
          bus.len = LW'(ql[v+1]);
        end
        wait_acc();
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    qa.delete();
    qb.delete();
    ql.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b1;
    #3;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_len_err", bus.len_err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_sload", macc_sload, 0);
    chk("rst_macc_a", macc_a, 0);
    chk("rst_macc_b", macc_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ce_after_rst", macc_ce, 1);
    qa = {1, 3, 5}; qb = {2, 4, 6}; ql = {3};
    waits = 0;
    drive(0);
    chk("no_bubble_single", waits, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency_early", bus.res_valid, 0);
    end
    @(negedge clk);
    chk("latency_capture", bus.res_valid, 1);
    @(posedge clk);
    #1;
    qa = {2, 4, -1, -2}; qb = {3, 5, 7, -3}; ql = {2, 2};
    waits = 0;
    drive(0);
    chk("no_bubble_b2b", waits, 0);
    repeat (10) @(posedge clk);
    #1;
    qa = {1, 3, 5}; qb = {2, 4, 6}; ql = {3};
    drive(2);
    repeat (10) @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    qa = {1, 2, 3, 1, 4, -2, 100, 6}; qb = {1, 2, 3, -1, 4, 5, -3, 7}; ql = {2, 2, 1, 1, 1, 1};
    fork
      drive(0);
      begin
        repeat (14) @(negedge clk);
        chk("stall_ce", macc_ce, 0);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_res_valid", bus.res_valid, 1);
        chk("stall_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.len = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("len0_err_pulse", bus.len_err, 1);
    chk("len0_busy", bus.busy, 0);
    @(negedge clk);
    chk("len0_err_clear", bus.len_err, 0);
    chk("len0_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.len = LW'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = SI'(1);
    bus.in_b = SI'(2);
    wait_acc();
    bus.in_a = SI'(3);
    bus.in_b = SI'(4);
    wait_acc();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_macc_a", macc_a, 0);
    chk("mid_rst_macc_b", macc_b, 0);
    chk("mid_rst_sload", macc_sload, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_ce", macc_ce, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa = {7}; qb = {-8}; ql = {1};
    drive(0);
    repeat (20) @(posedge clk);
    chk("all_results_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
